// File: rtl/tc_fetch_sequencer.sv
// rtl/tc_fetch_sequencer.sv - instruction-fetch front end: PC, in-flight tracking, instruction queue
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   mem_address  fetch address to the program memory (registered)
//   mem_data0..3 program memory byte lanes at address +0..+3, valid one cycle after the address
//   instr        instruction word at the queue head, little-endian byte assembly
//   instr_pc     address of the word on instr
//   instr_valid  queue head is valid
//   instr_ready  decode accepts the head when instr_valid && instr_ready
//   jump_valid   single-cycle redirect request
//   jump_target  redirect address, used as given
module tc_fetch_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_address,
    input  logic [7:0]  mem_data0,
    input  logic [7:0]  mem_data1,
    input  logic [7:0]  mem_data2,
    input  logic [7:0]  mem_data3,
    output logic [31:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump_valid,
    input  logic [15:0] jump_target
);

    localparam int              PW      = $clog2(QUEUE_DEPTH);
    localparam int              CW      = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(QUEUE_DEPTH);

    logic [15:0]   fetch_pc;

    // Stage A is the request issuing this cycle; stage B is the request whose
    // data is on mem_data* this cycle.
    logic          a_live;
    logic [15:0]   a_pc;
    logic          b_live;
    logic [15:0]   b_pc;

    logic [31:0]   q_data [QUEUE_DEPTH];
    logic [15:0]   q_pc   [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [CW-1:0] occupancy;
    logic          enq;
    logic          deq;

    // Words already queued plus the one still in flight; a new request is only
    // issued if its data is guaranteed a slot, so the queue never overflows.
    // The same-cycle dequeue is deliberately not credited.
    assign occupancy   = count + CW'(b_live);
    assign a_live      = !jump_valid && (occupancy < DEPTH_C);
    assign a_pc        = fetch_pc;

    // A jump squashes the landing word as well as everything queued.
    assign enq         = b_live && !jump_valid;
    assign deq         = instr_valid && instr_ready;

    assign mem_address = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = q_data[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            b_live   <= 1'b0;
            b_pc     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (jump_valid) begin
            fetch_pc <= jump_target;
            b_live   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (a_live) begin
                fetch_pc <= fetch_pc + 16'd4;
            end
            b_live <= a_live;
            b_pc   <= a_pc;
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so instr/instr_pc read as zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (enq) begin
            q_data[wr_ptr] <= {mem_data3, mem_data2, mem_data1, mem_data0};
            q_pc[wr_ptr]   <= b_pc;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(enq && (count == DEPTH_C)));

endmodule
